// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, command FSM states and default widths.
package alu_pkg;

  localparam int OPER_WIDTH_DEF = 8;
  localparam int OUT_WIDTH_DEF  = 2 * OPER_WIDTH_DEF;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_CAPT,
    S_SEND_LO,
    S_SEND_HI
  } state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command front-end: collects opcode/A/B, pulses the ALU once,
// and streams the 16-bit result back as low word then high word.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int OPER_WIDTH = OPER_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OPER_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_ERR,
  output logic                  OUT_LAST,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  BUSY
);

  state_e                state_q, state_d;
  logic [OPER_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]            alu_fun_q;
  logic                  opc_ok_q;
  logic [OUT_WIDTH-1:0]  res_q;
  logic                  err_q;

  logic in_xfer, out_xfer, err_det;

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = OUT_VALID & OUT_READY;
  // Reserved opcode, or divide by zero, is only known once B arrives.
  assign err_det  = ~opc_ok_q | ((alu_fun_q == OP_DIV) && (IN_DATA == '0));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_xfer) state_d = S_GET_A;
      S_GET_A:   if (in_xfer) state_d = S_GET_B;
      S_GET_B:   if (in_xfer) state_d = err_det ? S_SEND_LO : S_EXEC;
      S_EXEC:    state_d = S_CAPT;
      S_CAPT:    state_d = S_SEND_LO;
      S_SEND_LO: if (out_xfer) state_d = S_SEND_HI;
      S_SEND_HI: if (out_xfer) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    OUT_LAST  = 1'b0;
    OUT_ERR   = 1'b0;
    ALU_EN    = 1'b0;
    BUSY      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE, S_GET_A, S_GET_B: IN_READY = 1'b1;
      S_EXEC:                   ALU_EN   = 1'b1;
      S_SEND_LO: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = res_q[OPER_WIDTH-1:0];
        OUT_ERR   = err_q;
      end
      S_SEND_HI: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = res_q[OUT_WIDTH-1:OPER_WIDTH];
        OUT_LAST  = 1'b1;
        OUT_ERR   = err_q;
      end
      default: ;
    endcase
  end

  // Operand registers only move on their load edges so the ALU inputs stay quiet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      opc_ok_q  <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (in_xfer && state_q == S_IDLE) begin
        alu_fun_q <= IN_DATA[3:0];
        opc_ok_q  <= (IN_DATA[OPER_WIDTH-1:4] == '0) && (IN_DATA[3:0] != OP_RSVD);
      end
      if (in_xfer && state_q == S_GET_A) alu_a_q <= IN_DATA;
      if (in_xfer && state_q == S_GET_B) begin
        alu_b_q <= IN_DATA;
        if (err_det) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (state_q == S_CAPT) begin
        res_q <= ALU_OUT;
        err_q <= 1'b0;
      end
    end
  end

  assign ALU_A   = alu_a_q;
  assign ALU_B   = alu_b_q;
  assign ALU_FUN = alu_fun_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU model attached.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_ERR;
  logic        OUT_LAST;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        BUSY;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] outq[$];

  always #5 CLK = ~CLK;

  alu_cmd_ctrl #(.OPER_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_ERR(OUT_ERR), .OUT_LAST(OUT_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .BUSY(BUSY)
  );

  // External ALU: registered result, async active-low reset from ~RST.
  logic        alu_rst_n;
  logic [15:0] alu_q;
  assign alu_rst_n = ~RST;
  assign ALU_OUT   = alu_q;

  always @(posedge CLK or negedge alu_rst_n) begin
    if (!alu_rst_n) alu_q <= 16'h0;
    else if (ALU_EN) begin
      case (ALU_FUN)
        4'h0:    alu_q <= {8'h0, ALU_A} + {8'h0, ALU_B};
        4'h1:    alu_q <= {8'h0, ALU_A} - {8'h0, ALU_B};
        4'h2:    alu_q <= ALU_A * ALU_B;
        4'h3:    alu_q <= (ALU_B != 0) ? {8'h0, ALU_A / ALU_B} : 16'h0;
        4'h4:    alu_q <= {8'h0, ALU_A & ALU_B};
        default: alu_q <= 16'h0;
      endcase
    end
  end

  always @(posedge CLK) if (ALU_EN) en_cnt <= en_cnt + 1;
  always @(posedge CLK) if (mon_en && OUT_VALID && OUT_READY) outq.push_back(OUT_DATA);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge CLK);
    IN_DATA  = w;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check("in_ready_timeout", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  // Sends one frame and checks the two response words, their timing and the EN pulse.
  task automatic run_frame(input string tag, input logic [7:0] op, a, b,
                           input logic [7:0] exp_lo, exp_hi, input logic exp_err,
                           input int hold);
    int n, en0;
    logic exp_en;
    exp_en = !exp_err;
    en0 = en_cnt;
    if (hold > 0) OUT_READY = 1'b0;
    send_word(op);
    send_word(a);
    send_word(b);
    @(negedge CLK);
    check({tag, "_en_k1"}, 32'(ALU_EN), 32'(exp_en));
    n = 0;
    while (!OUT_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_lat"}, n, exp_err ? 0 : 2);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_bp_data"}, 32'(OUT_DATA), 32'(exp_lo));
      check({tag, "_bp_inrdy"}, 32'(IN_READY), 32'd0);
      check({tag, "_bp_vld"}, 32'(OUT_VALID), 32'd1);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    check({tag, "_lo"}, 32'(OUT_DATA), 32'(exp_lo));
    check({tag, "_lo_last"}, 32'(OUT_LAST), 32'd0);
    check({tag, "_lo_err"}, 32'(OUT_ERR), 32'(exp_err));
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_hi_vld"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_hi"}, 32'(OUT_DATA), 32'(exp_hi));
    check({tag, "_hi_last"}, 32'(OUT_LAST), 32'd1);
    check({tag, "_hi_err"}, 32'(OUT_ERR), 32'(exp_err));
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_idle"}, 32'(BUSY), 32'd0);
    check({tag, "_en_cnt"}, en_cnt - en0, 32'(exp_en));
  endtask

  initial begin
    logic [7:0] bw[6];
    int xc[6];
    int wi, en0;
    logic rdy_s;

    RST = 1'b1; IN_VALID = 1'b0; IN_DATA = 8'h00; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_last", 32'(OUT_LAST), 32'd0);
    check("rst_out_err", 32'(OUT_ERR), 32'd0);
    check("rst_out_data", 32'(OUT_DATA), 32'd0);
    check("rst_alu_en", 32'(ALU_EN), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_alu_abf", {12'h0, ALU_A, ALU_B, ALU_FUN}, 32'd0);

    run_frame("add", 8'h00, 8'h05, 8'h03, 8'h08, 8'h00, 1'b0, 0);
    check("add_operands", {12'h0, ALU_A, ALU_B, ALU_FUN}, {12'h0, 8'h05, 8'h03, 4'h0});
    run_frame("mul", 8'h02, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 0);
    run_frame("sub", 8'h01, 8'h03, 8'h05, 8'hFE, 8'hFF, 1'b0, 0);
    run_frame("div0", 8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 0);
    run_frame("rsvd", 8'h1F, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 0);
    run_frame("bp", 8'h00, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 5);

    // Reset after opcode and A, with B presented on the reset edge.
    en0 = en_cnt;
    send_word(8'h00);
    send_word(8'h11);
    @(negedge CLK);
    IN_DATA = 8'h07; IN_VALID = 1'b1; RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0;
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_in_ready", 32'(IN_READY), 32'd1);
    repeat (3) @(negedge CLK);
    check("midrst_no_en", en_cnt - en0, 32'd0);
    check("midrst_no_out", 32'(OUT_VALID), 32'd0);
    run_frame("and", 8'h04, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 0);

    // Back-to-back frames with IN_VALID and OUT_READY held high.
    bw = '{8'h00, 8'h05, 8'h03, 8'h01, 8'h03, 8'h05};
    xc = '{default: 0};
    wi = 0;
    outq.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      IN_VALID = (wi < 6);
      IN_DATA  = (wi < 6) ? bw[wi] : 8'h00;
      rdy_s    = IN_READY;
      @(posedge CLK);
      if (IN_VALID && rdy_s) begin
        xc[wi] = c;
        wi++;
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    mon_en = 1'b0;
    check("b2b_words", wi, 6);
    check("b2b_period", xc[3] - xc[0], 7);
    check("b2b_gap", xc[3] - xc[2], 5);
    check("b2b_outcnt", outq.size(), 4);
    if (outq.size() == 4) begin
      check("b2b_o0", 32'(outq[0]), 32'h08);
      check("b2b_o1", 32'(outq[1]), 32'h00);
      check("b2b_o2", 32'(outq[2]), 32'hFE);
      check("b2b_o3", 32'(outq[3]), 32'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
